adc_to_opfb_hls_deadlock_monitor_unit: RTL

Per-process deadlock monitor for the HLS dataflow region, the next generation of the per-process deadlock detect unit. It merges incoming channel dependence vectors, forwards its own dependence downstream, and runs the token-passing report chain. Unlike the earlier unit, it only reports a cycle after the cycle has persisted for a programmable number of clocks. It also latches a snapshot of the offending dependence set, counts confirmed deadlock events, and suppresses re-reports until the condition clears.

---
 rtl/adc_to_opfb_hls_deadlock_monitor_unit.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/adc_to_opfb_hls_deadlock_monitor_unit.sv
// ---------------------------------------------------------------------------
// adc_to_opfb_hls_deadlock_monitor_unit
//
// Per-process deadlock monitor for the HLS dataflow region. It merges the
// incoming channel dependence vectors and forwards this process's dependence
// downstream. It also runs the token-passing report chain. A dependence cycle
// through this process is reported only after it has persisted for
// CONFIRM_CYCLES consecutive clocks. On confirmation the offending
// dependence set is latched and a saturating event counter is bumped. A
// report acknowledged by token_clear is not repeated until the cycle clears.
//
// Ports:
//   clk                     rising-edge clock
//   rst_n                   asynchronous active-low reset
//   proc_dep_vld_vec_i      per-output-channel blocked indication
//   in_chan_dep_vld_vec_i   per-input-channel dependence valid
//   in_chan_dep_data_vec_i  packed dependence vectors, chan i at [i*PROC_NUM +: PROC_NUM]
//   token_in_vec_i          report token per input channel
//   dl_detect_in_i          global deadlock-detected flag
//   origin_i                this unit originates the report token
//   token_clear_i           report acknowledged
//   out_chan_dep_vld_vec_o  = proc_dep_vld_vec_i (combinational)
//   out_chan_dep_data_o     dep_q | own bit
//   token_out_vec_o         registered report token
//   dl_detect_out_o         high while a confirmed, unacknowledged deadlock is held
//   dl_dep_snapshot_o       dependence set latched on confirmation
//   dl_event_cnt_o          saturating count of confirmations
// ---------------------------------------------------------------------------
module adc_to_opfb_hls_deadlock_monitor_unit #(
  parameter int unsigned PROC_NUM       = 4,
  parameter int unsigned PROC_ID        = 0,
  parameter int unsigned IN_CHAN_NUM    = 2,
  parameter int unsigned OUT_CHAN_NUM   = 3,
  parameter int unsigned CONFIRM_CYCLES = 4,
  parameter int unsigned EVT_W          = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [OUT_CHAN_NUM-1:0]         proc_dep_vld_vec_i,
  input  logic [IN_CHAN_NUM-1:0]          in_chan_dep_vld_vec_i,
  input  logic [IN_CHAN_NUM*PROC_NUM-1:0] in_chan_dep_data_vec_i,
  input  logic [IN_CHAN_NUM-1:0]          token_in_vec_i,
  input  logic                            dl_detect_in_i,
  input  logic                            origin_i,
  input  logic                            token_clear_i,
  output logic [OUT_CHAN_NUM-1:0]         out_chan_dep_vld_vec_o,
  output logic [PROC_NUM-1:0]             out_chan_dep_data_o,
  output logic [OUT_CHAN_NUM-1:0]         token_out_vec_o,
  output logic                            dl_detect_out_o,
  output logic [PROC_NUM-1:0]             dl_dep_snapshot_o,
  output logic [EVT_W-1:0]                dl_event_cnt_o
);

  localparam int unsigned         CNT_W   = $clog2(CONFIRM_CYCLES + 1);
  localparam logic [CNT_W-1:0]    CNT_TGT = CNT_W'(CONFIRM_CYCLES);
  localparam logic [PROC_NUM-1:0] OWN_BIT = PROC_NUM'(1) << PROC_ID;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SUSPECT,
    S_CONFIRMED,
    S_REPORTED
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc;
  logic [PROC_NUM-1:0]     dep_q, dep_d;
  logic [PROC_NUM-1:0]     dep_comb, dep;
  logic [OUT_CHAN_NUM-1:0] token_q, token_d;
  logic [PROC_NUM-1:0]     snap_q;
  logic [EVT_W-1:0]        evt_q;
  logic                    open, blocked, raw, enter_conf;

  // Dependence merge, gating and suspect detection
  always_comb begin
    dep_comb = '0;
    for (int unsigned i = 0; i < IN_CHAN_NUM; i++) begin
      if (in_chan_dep_vld_vec_i[i]) begin
        dep_comb = dep_comb | in_chan_dep_data_vec_i[i*PROC_NUM +: PROC_NUM];
      end
    end
    // Once a deadlock is flagged globally, the dependence view is frozen
    // unless a report token is passing through this unit.
    open    = ~dl_detect_in_i | (|token_in_vec_i);
    dep     = open ? dep_comb : dep_q;
    blocked = |proc_dep_vld_vec_i;
    raw     = open & dep[PROC_ID] & blocked;
    dep_d   = blocked ? dep : '0;
    token_d = (((|token_in_vec_i) & ~token_clear_i) | origin_i) ? proc_dep_vld_vec_i : '0;
  end

  // Confirmation FSM: next state
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_conf = 1'b0;
    cnt_inc    = cnt_q + CNT_W'(1);
    unique case (state_q)
      S_IDLE: begin
        if (raw) begin
          cnt_d = CNT_W'(1);
          if (CONFIRM_CYCLES == 1) begin
            state_d    = S_CONFIRMED;
            enter_conf = 1'b1;
          end else begin
            state_d = S_SUSPECT;
          end
        end
      end
      S_SUSPECT: begin
        if (raw) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_TGT) begin
            state_d    = S_CONFIRMED;
            enter_conf = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      S_CONFIRMED: begin
        if (!raw) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (token_clear_i) begin
          state_d = S_REPORTED;
        end
      end
      S_REPORTED: begin
        if (!raw) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dep_q   <= '0;
      token_q <= '0;
      snap_q  <= '0;
      evt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dep_q   <= dep_d;
      token_q <= token_d;
      if (enter_conf) begin
        snap_q <= dep | OWN_BIT;
        if (evt_q != '1) begin
          evt_q <= evt_q + EVT_W'(1);
        end
      end
    end
  end

  assign out_chan_dep_vld_vec_o = proc_dep_vld_vec_i;
  assign out_chan_dep_data_o    = dep_q | OWN_BIT;
  assign token_out_vec_o        = token_q;
  assign dl_detect_out_o        = (state_q == S_CONFIRMED);
  assign dl_dep_snapshot_o      = snap_q;
  assign dl_event_cnt_o         = evt_q;

endmodule
